dmem_responder: RTL and testbench

- Target-side data-memory responder for the multicycle/pipelined MIPS core.
- The core's MEM stage issues load/store requests; this block accepts them over a valid/ready handshake and inserts a programmable number of wait states.
- It performs a byte-enabled word access on an internal 2^ADDR_W x 32 array and returns a single-cycle response.
- It drives a stall to the core while a request is outstanding, replacing the zero-latency DMem.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 197 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// byte-lane geometry, wait-counter width and the byte-merge helper used to
// form the post-write word of a store.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;
    localparam int WAITCNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Replace each enabled byte lane of oldWord with the same lane of newWord.
    function automatic logic [WORD_W-1:0] mergeBytes(
        input logic [WORD_W-1:0]     oldWord,
        input logic [WORD_W-1:0]     newWord,
        input logic [BYTE_LANES-1:0] be
    );
        logic [WORD_W-1:0] merged;
        merged = oldWord;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = newWord[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// 2^ADDR_W x DATA_W word storage with byte-enabled synchronous write and a
// combinational read port at the same address.
//
// Ports:
//   clk    in   system clock, rising edge
//   we     in   write enable for this cycle
//   addr   in   word address (shared by read and write)
//   wdata  in   write data
//   be     in   byte enables, bit i selects wdata[8i+7:8i]
//   rdata  out  current contents of mem[addr] (combinational)
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [BYTE_LANES-1:0] be,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset on purpose; contents survive a
    // reset and the array maps onto plain RAM without a clear port.
    // NOTE: clocked state is always assigned with <= so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Target-side data-memory responder for the MIPS core MEM stage. Accepts one
// load/store over a valid/ready handshake, waits WAIT_CYCLES cycles, performs
// the byte-enabled word access and returns a one-cycle response. While a
// request is outstanding it stalls the core.
//
// Build option:
//   DMEM_STATS_EN  when defined, adds saturating rd_count / wr_count outputs.
//
// Ports:
//   clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept (IDLE only)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   word address
//   req_wdata  in   store data
//   req_be     in   byte enables (stores only)
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  load data, or the post-write word for a store
//   stall      out  freeze core pipeline
//   rd_count   out  loads completed (DMEM_STATS_EN only)
//   wr_count   out  stores completed (DMEM_STATS_EN only)
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [BYTE_LANES-1:0] req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  stall
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    if (DATA_W != WORD_W || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gParamCheck
        $error("dmem_responder: DATA_W must be 32 and WAIT_CYCLES 0..15");
    end

    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAITCNT_W-1:0] WAIT_LOAD =
        ZERO_WAIT ? '0 : WAITCNT_W'(WAIT_CYCLES - 1);

    state_t                  state;
    state_t                  nextState;
    logic [WAITCNT_W-1:0]    waitCnt;

    logic                    latWe;
    logic [ADDR_W-1:0]       latAddr;
    logic [DATA_W-1:0]       latWdata;
    logic [BYTE_LANES-1:0]   latBe;

    logic                    accept;
    logic                    enterResp;
    logic                    doAccess;
    logic                    accWe;
    logic [ADDR_W-1:0]       accAddr;
    logic [DATA_W-1:0]       accWdata;
    logic [BYTE_LANES-1:0]   accBe;
    logic [DATA_W-1:0]       arrRdata;
    logic [DATA_W-1:0]       postWord;

    assign accept    = (state == ST_IDLE) && req_valid;
    // The access happens on the edge that moves the FSM into RESP: straight
    // from IDLE for a zero-wait build, otherwise when the countdown expires.
    assign enterResp = (accept && ZERO_WAIT) || ((state == ST_WAIT) && (waitCnt == '0));
    // A reset on that edge aborts the access, so a pending store never lands.
    assign doAccess  = enterResp && !Reset;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    nextState = ZERO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (waitCnt == '0) begin
                    nextState = ST_RESP;
                end
            end
            ST_RESP: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        stall     = ((state == ST_IDLE) && req_valid) || (state == ST_WAIT);
        rsp_valid = (state == ST_RESP) && !Reset;
    end

    // ------------------------------------------------------- wait counter
    always_ff @(posedge clk) begin
        if (Reset) begin
            waitCnt <= '0;
        end else if (accept) begin
            waitCnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (waitCnt != '0)) begin
            waitCnt <= waitCnt - WAITCNT_W'(1);
        end
    end

    // ------------------------------------------------------ request latch
    // Plain datapath capture: only consumed after an accept, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            latWe    <= req_we;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            latBe    <= req_be;
        end
    end

    // In a zero-wait build the access shares the accept edge, before the
    // latch has been loaded, so the live request fields are used in IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            accWe    = req_we;
            accAddr  = req_addr;
            accWdata = req_wdata;
            accBe    = req_be;
        end else begin
            accWe    = latWe;
            accAddr  = latAddr;
            accWdata = latWdata;
            accBe    = latBe;
        end
    end

    // --------------------------------------------------------------- array
    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uArray (
        .clk   (clk),
        .we    (doAccess && accWe),
        .addr  (accAddr),
        .wdata (accWdata),
        .be    (accBe),
        .rdata (arrRdata)
    );

    assign postWord = mergeBytes(arrRdata, accWdata, accBe);

    always_ff @(posedge clk) begin
        if (Reset) begin
            rsp_rdata <= '0;
        end else if (enterResp) begin
            rsp_rdata <= accWe ? postWord : arrRdata;
        end
    end

    // --------------------------------------------------------------- stats
`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (Reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (enterResp) begin
            if (accWe) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. A WAIT_CYCLES=2 instance runs
// directed and random load/store traffic against a word-array model; a
// WAIT_CYCLES=0 instance runs back-to-back traffic with req_valid held.
// Build option DMEM_STATS_EN adds checks of rd_count / wr_count.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int WAITN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;

    // WAIT_CYCLES = 2 instance
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, stall;
    logic [31:0] rsp_rdata;

    // WAIT_CYCLES = 0 instance
    logic        zValid, zReady, zWe;
    logic [7:0]  zAddr;
    logic [31:0] zWdata;
    logic [3:0]  zBe;
    logic        zRspValid, zStall;
    logic [31:0] zRdata;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count, wr_count, zRdCount, zWrCount;
`endif

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(WAITN)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .stall     (stall)
`ifdef DMEM_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (zValid),
        .req_ready (zReady),
        .req_we    (zWe),
        .req_addr  (zAddr),
        .req_wdata (zWdata),
        .req_be    (zBe),
        .rsp_valid (zRspValid),
        .rsp_rdata (zRdata),
        .stall     (zStall)
`ifdef DMEM_STATS_EN
        ,
        .rd_count  (zRdCount),
        .wr_count  (zWrCount)
`endif
    );

    int checkCount = 0;
    int errorCount = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the word array and completed-access counts since reset.
    logic [31:0] model [256];
    logic [31:0] zModel [8];
    int expRd = 0;
    int expWr = 0;

    function automatic logic [31:0] storeWord(input logic [31:0] oldWord,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
        logic [31:0] w;
        w = oldWord;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
        return w;
    endfunction

    // One complete transaction on the WAIT_CYCLES=2 instance, checking
    // handshake, stall, latency, response data and response pulse width.
    task automatic transact(input logic we, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] exp;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        #1;
        check("ready_idle", 32'(req_ready), 32'd1);
        check("stall_req", 32'(stall), 32'd1);
        @(posedge clk);
        exp = we ? storeWord(model[addr], wdata, be) : model[addr];
        if (we) begin
            model[addr] = exp;
            expWr++;
        end else begin
            expRd++;
        end
        @(negedge clk);
        // Garbage on the request bus after acceptance must be ignored.
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = 8'($urandom);
        req_wdata = $urandom; req_be = 4'($urandom);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            check("stall_wait", 32'(stall), 32'd1);
            check("ready_wait", 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(WAITN + 1));
        check("rsp_rdata", rsp_rdata, exp);
        check("stall_resp", 32'(stall), 32'd0);
        check("ready_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("rdata_hold", rsp_rdata, exp);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic checkIdleAfterReset(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
`ifdef DMEM_STATS_EN
        check({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        zValid = 1'b0; zWe = 1'b0; zAddr = '0; zWdata = '0; zBe = '0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        #1;
        checkIdleAfterReset("reset");
        check("z_reset_ready", 32'(zReady), 32'd1);
        check("z_reset_rsp", 32'(zRspValid), 32'd0);

        // ---- zero-wait instance: back-to-back stores then loads, valid held
        @(negedge clk);
        zValid = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                zWe    = (pass == 0);
                zAddr  = 8'((i * 3) % 8);
                zWdata = $urandom;
                zBe    = 4'hF;
                if (pass == 0) zModel[(i * 3) % 8] = zWdata;
                #1;
                check("z_stall_idle", 32'(zStall), 32'd1);
                check("z_ready_idle", 32'(zReady), 32'd1);
                check("z_rsp_idle", 32'(zRspValid), 32'd0);
                @(negedge clk);
                check("z_rsp_valid", 32'(zRspValid), 32'd1);
                check("z_stall_resp", 32'(zStall), 32'd0);
                check("z_ready_resp", 32'(zReady), 32'd0);
                check("z_rdata", zRdata, zModel[(i * 3) % 8]);
                @(negedge clk);
            end
        end
        zValid = 1'b0;

        // ---- directed traffic on the wait-state instance
        model[4] = 32'h0;
        transact(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
        transact(1'b0, 8'h04, 32'h0, 4'h0);
        check("dir_load_deadbeef", rsp_rdata, 32'hDEADBEEF);
        transact(1'b1, 8'h04, 32'h11223344, 4'b0101);
        transact(1'b0, 8'h04, 32'h0, 4'h0);
        check("dir_merge", rsp_rdata, 32'hDE22BE44);

        // ---- preload every word so later loads have known contents
        for (int a = 0; a < 256; a++) begin
            transact(1'b1, 8'(a), (a == 8'h10) ? 32'h0 : $urandom, 4'hF);
        end

        // ---- reset on the edge that would have committed a pending store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10;
        req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_stall", 32'(stall), 32'd1);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        checkIdleAfterReset("abort");
        expRd = 0; expWr = 0;
        repeat (4) begin
            @(negedge clk);
            check("abort_quiet", 32'(rsp_valid), 32'd0);
        end
        transact(1'b0, 8'h10, 32'h0, 4'h0);
        check("abort_kept_old", rsp_rdata, 32'h0);

        // ---- reset during RESP: store stays committed, strobe forced low
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk);
        model[8'h20] = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("resp_rst_latency", 32'(n), 32'(WAITN + 1));
        Reset = 1'b1;
        #1;
        check("resp_rst_forced", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        checkIdleAfterReset("resp_rst");
        expRd = 0; expWr = 0;
        transact(1'b0, 8'h20, 32'h0, 4'h0);

        // ---- empty byte mask: array untouched, response still issued
        transact(1'b1, 8'h30, 32'h12345678, 4'h0);
        transact(1'b0, 8'h30, 32'h0, 4'h0);

        // ---- random traffic
        for (int t = 0; t < 150; t++) begin
            logic [3:0] be;
            be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            transact(1'($urandom), 8'($urandom), $urandom, be);
        end

`ifdef DMEM_STATS_EN
        check("stats_rd", 32'(rd_count), 32'(expRd));
        check("stats_wr", 32'(wr_count), 32'(expWr));
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check("stats_rd_clr", 32'(rd_count), 32'd0);
        check("stats_wr_clr", 32'(wr_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule : tb_dmem_responder
